// File: rtl/midi_parser_pkg.sv
// Shared MIDI types for the parser: data-byte width, status nibbles and FSM states.
package midi_parser_pkg;

  localparam int BITS = 7;
  typedef logic [BITS-1:0] bits_t;

  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] POLY_AT    = 4'hA;
  localparam logic [3:0] CTRL_CHG   = 4'hB;
  localparam logic [3:0] PROG_CHG   = 4'hC;
  localparam logic [3:0] CHAN_AT    = 4'hD;
  localparam logic [3:0] PITCH_BEND = 4'hE;
  localparam logic [3:0] SYSTEM     = 4'hF;
  localparam logic [3:0] NO_STATUS  = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_VEL   = 3'd2,
    ST_SKIP2 = 3'd3,
    ST_SKIP1 = 3'd4
  } state_t;

  // Program change and channel aftertouch carry a single data byte.
  function automatic logic is_two_byte(input logic [3:0] nib);
    return !((nib == PROG_CHG) || (nib == CHAN_AT));
  endfunction

endpackage

// File: rtl/midi_parser_if.sv
// Byte-in / note-event-out bundle between the UART receiver, the parser and the video block.
interface midi_parser_if;
  import midi_parser_pkg::*;

  logic [7:0] data;
  logic       data_valid;
  bits_t      note;
  bits_t      velocity;
  logic       event_valid;
  logic       error;

  modport master (
    output data, data_valid,
    input  note, velocity, event_valid, error
  );

  modport slave (
    input  data, data_valid,
    output note, velocity, event_valid, error
  );

endinterface

// File: rtl/midi_parser.sv
// MIDI byte-stream parser: tracks running status and reports Note On/Off events
// for one channel (or all channels in omni mode) as note/velocity updates.
//
//   state    | meaning
//   ST_IDLE  | no running status; data bytes are errors
//   ST_KEY   | note message active, awaiting key byte
//   ST_VEL   | key latched, awaiting velocity byte
//   ST_SKIP2 | unused message, two data bytes left to discard
//   ST_SKIP1 | unused message, one data byte left to discard
module midi_parser
  import midi_parser_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter bit OMNI    = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  midi_parser_if.slave    bus
);

  state_t     state_q, state_d;
  logic [3:0] status_q, status_d;
  bits_t      key_q, key_d;
  bits_t      note_q, note_d;
  bits_t      vel_q, vel_d;
  logic       event_q, event_d;
  logic       error_q, error_d;

  logic       is_status;
  logic [3:0] nib;
  logic       ch_match;

  assign is_status = bus.data[7];
  assign nib       = bus.data[7:4];
  assign ch_match  = OMNI || (bus.data[3:0] == 4'(CHANNEL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      status_q <= NO_STATUS;
      key_q    <= '0;
      note_q   <= '0;
      vel_q    <= '0;
      event_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      key_q    <= key_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      event_q  <= event_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    key_d    = key_q;
    note_d   = note_q;
    vel_d    = vel_q;
    event_d  = 1'b0;
    error_d  = 1'b0;

    if (bus.data_valid) begin
      if (is_status) begin
        if (nib == SYSTEM) begin
          // Realtime bytes (F8-FF) may interleave anything and leave no trace.
          if (!bus.data[3]) begin
            state_d  = ST_IDLE;
            status_d = NO_STATUS;
          end
        end else begin
          status_d = nib;
          unique case (nib)
            NOTE_OFF, NOTE_ON:            state_d = ch_match ? ST_KEY : ST_SKIP2;
            POLY_AT, CTRL_CHG, PITCH_BEND: state_d = ST_SKIP2;
            PROG_CHG, CHAN_AT:            state_d = ST_SKIP1;
            default:                      state_d = ST_IDLE;
          endcase
        end
      end else begin
        unique case (state_q)
          ST_IDLE: error_d = 1'b1;
          ST_KEY: begin
            key_d   = bus.data[6:0];
            state_d = ST_VEL;
          end
          ST_VEL: begin
            state_d = ST_KEY;
            if ((status_q == NOTE_ON) && (bus.data[6:0] != '0)) begin
              note_d  = key_q;
              vel_d   = bus.data[6:0];
              event_d = 1'b1;
            end else if (key_q == note_q) begin
              // A release only matters for the note currently shown.
              vel_d   = '0;
              event_d = 1'b1;
            end
          end
          ST_SKIP2: state_d = ST_SKIP1;
          ST_SKIP1: state_d = is_two_byte(status_q) ? ST_SKIP2 : ST_SKIP1;
          default:  state_d = ST_IDLE;
        endcase
      end
    end
  end

  assign bus.note        = note_q;
  assign bus.velocity    = vel_q;
  assign bus.event_valid = event_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_midi_parser.sv
// Directed bench for midi_parser: a channel-0 instance and an omni instance fed the same bytes.
module tb_midi_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ev_a = 0, ev_b = 0, er_a = 0;
  int   ev0, eb0, er0;

  always #5 clk = ~clk;

  midi_parser_if bus_a ();
  midi_parser_if bus_b ();

  midi_parser #(.CHANNEL(0), .OMNI(1'b0)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  midi_parser #(.CHANNEL(0), .OMNI(1'b1)) u_omni (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  always @(posedge clk) begin
    if (bus_a.event_valid) ev_a <= ev_a + 1;
    if (bus_b.event_valid) ev_b <= ev_b + 1;
    if (bus_a.error)       er_a <= er_a + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus_a.data = b; bus_a.data_valid = 1'b1;
    bus_b.data = b; bus_b.data_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus_a.data_valid = 1'b0;
    bus_b.data_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus_a.data_valid = 1'b0;
    bus_b.data_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic snap();
    ev0 = ev_a; eb0 = ev_b; er0 = er_a;
  endtask

  initial begin
    bus_a.data = 8'h00; bus_a.data_valid = 1'b0;
    bus_b.data = 8'h00; bus_b.data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_note", int'(bus_a.note), 0);
    chk("rst_vel",  int'(bus_a.velocity), 0);
    chk("rst_ev",   int'(bus_a.event_valid), 0);
    chk("rst_err",  int'(bus_a.error), 0);
    rst_n = 1'b1;
    idle(2);

    // Note On, checked exactly one cycle after the velocity byte
    snap();
    send(8'h90); send(8'h3C); send(8'h64);
    idle(1);
    chk("on_ev_lat", int'(bus_a.event_valid), 1);
    chk("on_note",   int'(bus_a.note), 60);
    chk("on_vel",    int'(bus_a.velocity), 100);
    idle(1);
    chk("on_ev_one", int'(bus_a.event_valid), 0);
    idle(2);
    chk("on_cnt", ev_a - ev0, 1);

    // Running status, back-to-back bytes
    snap();
    send(8'h40); send(8'h20);
    idle(1);
    chk("rs_note", int'(bus_a.note), 64);
    chk("rs_vel",  int'(bus_a.velocity), 32);
    send(8'h40); send(8'h00);
    idle(1);
    chk("rs0_note", int'(bus_a.note), 64);
    chk("rs0_vel",  int'(bus_a.velocity), 0);
    idle(2);
    chk("rs_cnt", ev_a - ev0, 2);

    // Realtime byte in the middle of a message
    snap();
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    idle(1);
    chk("rt_note", int'(bus_a.note), 60);
    chk("rt_vel",  int'(bus_a.velocity), 100);
    idle(2);
    chk("rt_cnt", ev_a - ev0, 1);

    // Note Off for a different key is ignored, matching key releases
    snap();
    send(8'h80); send(8'h3D); send(8'h40);
    idle(3);
    chk("off_other_cnt", ev_a - ev0, 0);
    chk("off_other_vel", int'(bus_a.velocity), 100);
    send(8'h3C); send(8'h00);
    idle(1);
    chk("off_vel",  int'(bus_a.velocity), 0);
    chk("off_note", int'(bus_a.note), 60);
    idle(2);
    chk("off_cnt", ev_a - ev0, 1);

    // Channel 1: filtered by the channel-0 instance, accepted in omni mode
    snap();
    send(8'h91); send(8'h3C); send(8'h64);
    idle(3);
    chk("ch1_cnt",     ev_a - ev0, 0);
    chk("ch1_vel",     int'(bus_a.velocity), 0);
    chk("omni_cnt",    ev_b - eb0, 1);
    chk("omni_note",   int'(bus_b.note), 60);
    chk("omni_vel",    int'(bus_b.velocity), 100);

    // Status byte while awaiting velocity aborts the partial message
    snap();
    send(8'h90); send(8'h3C); send(8'h90); send(8'h3D); send(8'h50);
    idle(3);
    chk("abort_cnt",  ev_a - ev0, 1);
    chk("abort_note", int'(bus_a.note), 61);
    chk("abort_vel",  int'(bus_a.velocity), 80);

    // Data byte with no running status after reset
    pulse_reset();
    chk("rst2_note", int'(bus_a.note), 0);
    snap();
    send(8'h3C);
    idle(1);
    chk("idle_err", int'(bus_a.error), 1);
    idle(1);
    chk("idle_err_one", int'(bus_a.error), 0);
    chk("idle_vel", int'(bus_a.velocity), 0);
    idle(1);
    chk("idle_err_cnt", er_a - er0, 1);

    // Control change with running status is discarded silently
    snap();
    send(8'hB0); send(8'h07); send(8'h7F); send(8'h07); send(8'h00);
    idle(3);
    chk("cc_ev",  ev_a - ev0, 0);
    chk("cc_err", er_a - er0, 0);

    // Program change (one data byte), then sysex clears running status
    snap();
    send(8'hC0); send(8'h05); send(8'h06);
    idle(2);
    chk("pc_err", er_a - er0, 0);
    send(8'hF0); send(8'h3C);
    idle(3);
    chk("sysex_err", er_a - er0, 1);

    // Reset mid-message discards the key
    snap();
    send(8'h90); send(8'h3C);
    pulse_reset();
    send(8'h64);
    idle(1);
    chk("mid_err",  int'(bus_a.error), 1);
    chk("mid_note", int'(bus_a.note), 0);
    chk("mid_vel",  int'(bus_a.velocity), 0);
    idle(2);
    chk("mid_cnt", ev_a - ev0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
